// File: rtl/decode.sv
// ----------------------------------------------------------------------------
// decode -- MIPS instruction decoder for the pipelined CPU.
//
// Maps one 32-bit instruction word to the control fields used by the
// execute-stage ALU and the multiply/divide unit. It also flags reserved
// instructions for the exception logic. Decoding is stateless, so each word
// is handled on its own.
//
// Ports:
//   clk        clock; used only when DECODE_REG_OUT_EN is defined
//   reset      synchronous, active-high; used only when DECODE_REG_OUT_EN is defined
//   instr      instruction word
//   ALUOp      ALU operation code (15 = no ALU operation / reserved)
//   MDOp       multiply/divide-unit operation code
//   start      starts a multiply/divide operation
//   add_instr  instruction traps on signed add overflow (add, addi)
//   sub_instr  instruction traps on signed subtract overflow (sub)
//   imm_sel    ALU B operand is the extended immediate (0 selects rt)
//   ext_op     immediate extension: 0 zero, 1 sign, 2 imm<<16
//   reg_dst    write register select: 0 rd, 1 rt, 2 $31
//   reg_we     GPR write enable
//   ri         reserved/unknown instruction; all other outputs are 0 and ALUOp is 15
//
// Configuration macro:
//   DECODE_REG_OUT_EN  When defined, every output is registered on posedge clk
//                      and has 1-cycle latency. Reset forces all outputs,
//                      including ALUOp, to 0. When undefined, the block is
//                      purely combinational.
// ----------------------------------------------------------------------------
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic [3:0]  ALUOp,
    output logic [3:0]  MDOp,
    output logic        start,
    output logic        add_instr,
    output logic        sub_instr,
    output logic        imm_sel,
    output logic [1:0]  ext_op,
    output logic [1:0]  reg_dst,
    output logic        reg_we,
    output logic        ri
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_OR   = 4'd2,  ALU_SLL  = 4'd3,
        ALU_SRL  = 4'd4,  ALU_SRA  = 4'd5,  ALU_SLLV = 4'd6,  ALU_SRLV = 4'd7,
        ALU_SRAV = 4'd8,  ALU_AND  = 4'd9,  ALU_XOR  = 4'd10, ALU_NOR  = 4'd11,
        ALU_SLT  = 4'd12, ALU_SLTU = 4'd13, ALU_NONE = 4'd15
    } alu_op_e;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0, MD_MULT = 4'd1, MD_MULTU = 4'd2, MD_DIV  = 4'd3,
        MD_DIVU = 4'd4, MD_MTHI = 4'd5, MD_MTLO  = 4'd6, MD_MFHI = 4'd7,
        MD_MFLO = 4'd8
    } md_op_e;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [1:0] DST_RD  = 2'd0;
    localparam logic [1:0] DST_RT  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rt    = instr[20:16];

    alu_op_e    aluop_d;
    md_op_e     mdop_d;
    logic       start_d;
    logic       add_instr_d;
    logic       sub_instr_d;
    logic       imm_sel_d;
    logic [1:0] ext_op_d;
    logic [1:0] reg_dst_d;
    logic       reg_we_d;
    logic       ri_d;

    // Every field is left at its idle value until the opcode is recognised.
    // An unrecognised word sets only ri, so the reserved encoding needs no
    // separate clean-up step.
    always_comb begin
        // NOTE: assign every output a default first, so that no path through
        // the case statements infers a latch.
        aluop_d     = ALU_NONE;
        mdop_d      = MD_NONE;
        start_d     = 1'b0;
        add_instr_d = 1'b0;
        sub_instr_d = 1'b0;
        imm_sel_d   = 1'b0;
        ext_op_d    = EXT_ZERO;
        reg_dst_d   = DST_RD;
        reg_we_d    = 1'b0;
        ri_d        = 1'b0;

        case (op)
            6'h00: begin
                // R-type: the destination is rd and the B operand is rt.
                case (funct)
                    6'h20: begin aluop_d = ALU_ADD;  reg_we_d = 1'b1; add_instr_d = 1'b1; end
                    6'h21: begin aluop_d = ALU_ADD;  reg_we_d = 1'b1; end
                    6'h22: begin aluop_d = ALU_SUB;  reg_we_d = 1'b1; sub_instr_d = 1'b1; end
                    6'h23: begin aluop_d = ALU_SUB;  reg_we_d = 1'b1; end
                    6'h24: begin aluop_d = ALU_AND;  reg_we_d = 1'b1; end
                    6'h25: begin aluop_d = ALU_OR;   reg_we_d = 1'b1; end
                    6'h26: begin aluop_d = ALU_XOR;  reg_we_d = 1'b1; end
                    6'h27: begin aluop_d = ALU_NOR;  reg_we_d = 1'b1; end
                    6'h2A: begin aluop_d = ALU_SLT;  reg_we_d = 1'b1; end
                    6'h2B: begin aluop_d = ALU_SLTU; reg_we_d = 1'b1; end
                    6'h00: begin aluop_d = ALU_SLL;  reg_we_d = 1'b1; end  // includes the all-zero nop
                    6'h02: begin aluop_d = ALU_SRL;  reg_we_d = 1'b1; end
                    6'h03: begin aluop_d = ALU_SRA;  reg_we_d = 1'b1; end
                    6'h04: begin aluop_d = ALU_SLLV; reg_we_d = 1'b1; end
                    6'h06: begin aluop_d = ALU_SRLV; reg_we_d = 1'b1; end
                    6'h07: begin aluop_d = ALU_SRAV; reg_we_d = 1'b1; end
                    6'h18: begin mdop_d = MD_MULT;  start_d = 1'b1; end
                    6'h19: begin mdop_d = MD_MULTU; start_d = 1'b1; end
                    6'h1A: begin mdop_d = MD_DIV;   start_d = 1'b1; end
                    6'h1B: begin mdop_d = MD_DIVU;  start_d = 1'b1; end
                    6'h11: mdop_d = MD_MTHI;
                    6'h13: mdop_d = MD_MTLO;
                    6'h10: begin mdop_d = MD_MFHI; reg_we_d = 1'b1; end
                    6'h12: begin mdop_d = MD_MFLO; reg_we_d = 1'b1; end
                    6'h08: ;                                  // jr: no register write
                    6'h09: reg_we_d = 1'b1;                   // jalr: link into rd
                    default: ri_d = 1'b1;
                endcase
            end
            6'h01: begin
                // REGIMM: only bltz (rt=0) and bgez (rt=1) are implemented.
                if (rt == 5'd0 || rt == 5'd1) begin
                    aluop_d   = ALU_SUB;
                    imm_sel_d = 1'b1;
                    reg_dst_d = DST_RT;
                end else begin
                    ri_d = 1'b1;
                end
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin                 // beq/bne/blez/bgtz
                aluop_d   = ALU_SUB;
                imm_sel_d = 1'b1;
                reg_dst_d = DST_RT;
            end
            6'h02: begin                                      // j
                imm_sel_d = 1'b1;
                reg_dst_d = DST_RT;
            end
            6'h03: begin                                      // jal: link into $31
                imm_sel_d = 1'b1;
                reg_dst_d = DST_R31;
                reg_we_d  = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                // Immediate ALU ops and loads write rt from an extended immediate.
                imm_sel_d = 1'b1;
                reg_dst_d = DST_RT;
                reg_we_d  = 1'b1;
                ext_op_d  = EXT_SIGN;
                aluop_d   = ALU_ADD;
                case (op)
                    6'h08:   add_instr_d = 1'b1;
                    6'h0A:   aluop_d = ALU_SLT;
                    6'h0B:   aluop_d = ALU_SLTU;
                    6'h0C:   begin aluop_d = ALU_AND; ext_op_d = EXT_ZERO; end
                    6'h0D:   begin aluop_d = ALU_OR;  ext_op_d = EXT_ZERO; end
                    6'h0E:   begin aluop_d = ALU_XOR; ext_op_d = EXT_ZERO; end
                    6'h0F:   ext_op_d = EXT_LUI;
                    default: ;
                endcase
            end
            6'h28, 6'h29, 6'h2B: begin                        // sb/sh/sw
                aluop_d   = ALU_ADD;
                imm_sel_d = 1'b1;
                ext_op_d  = EXT_SIGN;
                reg_dst_d = DST_RT;
            end
            default: ri_d = 1'b1;
        endcase
    end

`ifdef DECODE_REG_OUT_EN
    logic [3:0] aluop_q;
    logic [3:0] mdop_q;
    logic       start_q;
    logic       add_instr_q;
    logic       sub_instr_q;
    logic       imm_sel_q;
    logic [1:0] ext_op_q;
    logic [1:0] reg_dst_q;
    logic       reg_we_q;
    logic       ri_q;

    // Reset takes priority over capture. The word presented during a reset
    // cycle is therefore dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples the values from before the edge.
        if (reset) begin
            aluop_q     <= '0;
            mdop_q      <= '0;
            start_q     <= 1'b0;
            add_instr_q <= 1'b0;
            sub_instr_q <= 1'b0;
            imm_sel_q   <= 1'b0;
            ext_op_q    <= '0;
            reg_dst_q   <= '0;
            reg_we_q    <= 1'b0;
            ri_q        <= 1'b0;
        end else begin
            aluop_q     <= aluop_d;
            mdop_q      <= mdop_d;
            start_q     <= start_d;
            add_instr_q <= add_instr_d;
            sub_instr_q <= sub_instr_d;
            imm_sel_q   <= imm_sel_d;
            ext_op_q    <= ext_op_d;
            reg_dst_q   <= reg_dst_d;
            reg_we_q    <= reg_we_d;
            ri_q        <= ri_d;
        end
    end

    assign ALUOp     = aluop_q;
    assign MDOp      = mdop_q;
    assign start     = start_q;
    assign add_instr = add_instr_q;
    assign sub_instr = sub_instr_q;
    assign imm_sel   = imm_sel_q;
    assign ext_op    = ext_op_q;
    assign reg_dst   = reg_dst_q;
    assign reg_we    = reg_we_q;
    assign ri        = ri_q;

    // Register and immediate fields are decoded by other stages, not here.
    logic unused_ok;
    assign unused_ok = &{1'b0, instr[25:21], instr[15:6]};
`else
    assign ALUOp     = aluop_d;
    assign MDOp      = mdop_d;
    assign start     = start_d;
    assign add_instr = add_instr_d;
    assign sub_instr = sub_instr_d;
    assign imm_sel   = imm_sel_d;
    assign ext_op    = ext_op_d;
    assign reg_dst   = reg_dst_d;
    assign reg_we    = reg_we_d;
    assign ri        = ri_d;

    // clk and reset exist only for the registered build. The register and
    // immediate fields are decoded elsewhere.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset, instr[25:21], instr[15:6]};
`endif

endmodule

// File: tb/tb_decode.sv
// ----------------------------------------------------------------------------
// tb_decode -- scoreboard bench for decode.
//
// The stimulus process drives instruction words. For each word it pushes the
// expected control fields, tagged with the cycle in which they must appear.
// The reference model looks up opcode/funct tables that are filled in from
// the instruction list. A monitor process samples the outputs on the falling
// edge and compares them against the queue head.
// ----------------------------------------------------------------------------
module tb_decode;

    typedef struct packed {
        logic [3:0] alu;
        logic [3:0] md;
        logic       start;
        logic       add;
        logic       sub;
        logic       imm;
        logic [1:0] ext;
        logic [1:0] dst;
        logic       we;
        logic       ri;
    } ctl_t;

    typedef struct {
        int          due;
        logic [31:0] instr;
        ctl_t        exp;
    } sb_item_t;

`ifdef DECODE_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  ALUOp;
    logic [3:0]  MDOp;
    logic        start;
    logic        add_instr;
    logic        sub_instr;
    logic        imm_sel;
    logic [1:0]  ext_op;
    logic [1:0]  reg_dst;
    logic        reg_we;
    logic        ri;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sb_item_t sb_q[$];

    decode dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .ALUOp     (ALUOp),
        .MDOp      (MDOp),
        .start     (start),
        .add_instr (add_instr),
        .sub_instr (sub_instr),
        .imm_sel   (imm_sel),
        .ext_op    (ext_op),
        .reg_dst   (reg_dst),
        .reg_we    (reg_we),
        .ri        (ri)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model: table lookup ----------------
    ctl_t r_tab[64];
    bit   r_ok[64];
    ctl_t i_tab[64];
    bit   i_ok[64];

    function automatic ctl_t mk(int alu, int md, bit st, bit imm, int ext, int dst, bit we);
        ctl_t c;
        c       = '0;
        c.alu   = 4'(alu);
        c.md    = 4'(md);
        c.start = st;
        c.imm   = imm;
        c.ext   = 2'(ext);
        c.dst   = 2'(dst);
        c.we    = we;
        return c;
    endfunction

    task automatic add_r(int f, int alu, int md, bit st, bit we);
        r_tab[f] = mk(alu, md, st, 0, 0, 0, we);
        r_ok[f]  = 1;
    endtask

    task automatic add_i(int o, int alu, int ext, int dst, bit we);
        i_tab[o] = mk(alu, 0, 0, 1, ext, dst, we);
        i_ok[o]  = 1;
    endtask

    task automatic build_tables();
        for (int k = 0; k < 64; k++) begin r_ok[k] = 0; i_ok[k] = 0; end
        add_r('h20, 0, 0, 0, 1); add_r('h21, 0, 0, 0, 1);
        add_r('h22, 1, 0, 0, 1); add_r('h23, 1, 0, 0, 1);
        add_r('h24, 9, 0, 0, 1); add_r('h25, 2, 0, 0, 1);
        add_r('h26, 10, 0, 0, 1); add_r('h27, 11, 0, 0, 1);
        add_r('h2A, 12, 0, 0, 1); add_r('h2B, 13, 0, 0, 1);
        add_r('h00, 3, 0, 0, 1); add_r('h02, 4, 0, 0, 1); add_r('h03, 5, 0, 0, 1);
        add_r('h04, 6, 0, 0, 1); add_r('h06, 7, 0, 0, 1); add_r('h07, 8, 0, 0, 1);
        for (int k = 0; k < 4; k++) add_r('h18 + k, 15, 1 + k, 1, 0);
        add_r('h11, 15, 5, 0, 0); add_r('h13, 15, 6, 0, 0);
        add_r('h10, 15, 7, 0, 1); add_r('h12, 15, 8, 0, 1);
        add_r('h08, 15, 0, 0, 0); add_r('h09, 15, 0, 0, 1);
        r_tab['h20].add = 1;
        r_tab['h22].sub = 1;

        add_i('h08, 0, 1, 1, 1); add_i('h09, 0, 1, 1, 1);
        add_i('h0A, 12, 1, 1, 1); add_i('h0B, 13, 1, 1, 1);
        add_i('h0C, 9, 0, 1, 1); add_i('h0D, 2, 0, 1, 1); add_i('h0E, 10, 0, 1, 1);
        add_i('h0F, 0, 2, 1, 1);
        foreach (i_ok[k]) if (k inside {'h20, 'h21, 'h23, 'h24, 'h25}) add_i(k, 0, 1, 1, 1);
        foreach (i_ok[k]) if (k inside {'h28, 'h29, 'h2B}) add_i(k, 0, 1, 1, 0);
        for (int k = 4; k < 8; k++) add_i(k, 1, 0, 1, 0);
        add_i('h02, 15, 0, 1, 0);
        add_i('h03, 15, 0, 2, 1);
        i_tab['h08].add = 1;
    endtask

    function automatic ctl_t model(logic [31:0] w);
        ctl_t resv;
        int   o, f, r;
        resv     = '0;
        resv.alu = 4'd15;
        resv.ri  = 1'b1;
        o = int'(w >> 26);
        f = int'(w & 32'h3F);
        r = int'((w >> 16) & 32'h1F);
        if (o == 0)      return r_ok[f] ? r_tab[f] : resv;
        else if (o == 1) return (r < 2) ? mk(1, 0, 0, 1, 0, 1, 0) : resv;
        else             return i_ok[o] ? i_tab[o] : resv;
    endfunction

    // ---------------- stimulus ----------------
    task automatic issue(logic [31:0] w, logic rst);
        sb_item_t it;
        @(posedge clk);
        #1;
        instr = w;
        reset = rst;
        it.due   = cyc + LAT;
        it.instr = w;
        it.exp   = (LAT == 1 && rst) ? ctl_t'('0) : model(w);
        sb_q.push_back(it);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ctl_t got;
        got = {ALUOp, MDOp, start, add_instr, sub_instr, imm_sel, ext_op, reg_dst, reg_we, ri};
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            sb_item_t it;
            it = sb_q.pop_front();
            checks++;
            if (it.due < cyc) begin
                errors++;
                $display("FAIL missed_slot instr=%h due=%0d now=%0d", it.instr, it.due, cyc);
            end else if (got !== it.exp) begin
                errors++;
                $display("FAIL decode instr=%h got alu=%0d md=%0d st=%b add=%b sub=%b imm=%b ext=%0d dst=%0d we=%b ri=%b required alu=%0d md=%0d st=%b add=%b sub=%b imm=%b ext=%0d dst=%0d we=%b ri=%b",
                         it.instr, got.alu, got.md, got.start, got.add, got.sub, got.imm, got.ext, got.dst, got.we, got.ri,
                         it.exp.alu, it.exp.md, it.exp.start, it.exp.add, it.exp.sub, it.exp.imm, it.exp.ext, it.exp.dst, it.exp.we, it.exp.ri);
            end
        end
    end

    logic [31:0] directed[$] = '{
        32'h00221820, 32'h00221822, 32'h00221823, 32'h00220018, 32'h00001810,
        32'h34011234, 32'hFC000000, 32'h00000000, 32'h3C01ABCD, 32'h04010003,
        32'h04020003, 32'h0C000000, 32'h03E00008, 32'h8C220004, 32'hAC220004,
        32'h20210005, 32'h00000013, 32'h0000003F
    };

    initial begin
        build_tables();
        reset = 1'b1;
        instr = 32'h0;
        repeat (2) @(posedge clk);

        // Reset state, then the directed list.
        issue(32'h00000000, 1'b1);
        issue(32'h00221820, 1'b1);
        foreach (directed[k]) issue(directed[k], 1'b0);

        // Reset asserted with add applied, then add released.
        issue(32'h00221820, 1'b1);
        issue(32'h00221820, 1'b0);
        issue(32'h00221822, 1'b0);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] w;
            logic [5:0]  sel;
            w = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: w[31:26] = 6'h00;
                2: begin sel = 6'($urandom_range(0, 47)); w[31:26] = sel; end
                default: begin w[31:26] = 6'h01; w[20:16] = 5'($urandom_range(0, 3)); end
            endcase
            // Occasional mid-stream reset pulses.
            issue(w, ($urandom_range(0, 31) == 0));
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 8 && sb_q.size() > 0; k++) @(negedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

Combinational MIPS instruction decoder for the pipelined CPU. It maps one 32-bit instruction word to the control fields consumed by the execute-stage ALU and multiply/divide unit, and flags reserved instructions for the exception logic. One instance sits beside each stage that needs control bits, so decoding is stateless per instruction.

## Interface
Parameters: none.

Ports:
- clk  input  1  clock; used only when the registered-output option is compiled in (see Configuration)
- reset  input  1  synchronous, active-high; used only when the registered-output option is compiled in
- instr  input  32  instruction word
- ALUOp  output  4  ALU operation code
- MDOp  output  4  multiply/divide-unit operation code
- start  output  1  starts a multiply/divide operation
- add_instr  output  1  instruction traps on signed add overflow
- sub_instr  output  1  instruction traps on signed subtract overflow
- imm_sel  output  1  ALU B operand comes from the extended immediate; 0 selects rt
- ext_op  output  2  immediate extension: 0 zero-extend, 1 sign-extend, 2 `imm<<16`
- reg_dst  output  2  write register select: 0 rd, 1 rt, 2 $31
- reg_we  output  1  GPR write enable
- ri  output  1  reserved/unknown instruction

## Operation
Fields: `op=instr[31:26]`, `funct=instr[5:0]`, `rt=instr[20:16]`.

ALUOp codes:
- 0 add, 1 sub, 2 or, 3 sll, 4 srl, 5 sra, 6 sllv, 7 srlv, 8 srav, 9 and, 10 xor, 11 nor, 12 slt (signed), 13 sltu
- 15 is the default for anything not listed.

MDOp codes:
- 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo.

R-type (`op=0`), all with reg_dst=0 and reg_we=1 unless noted:
- add/addu 0x20/0x21 → ALUOp 0; sub/subu 0x22/0x23 → ALUOp 1.
- and/or/xor/nor 0x24–0x27 → ALUOp 9/2/10/11; slt/sltu 0x2A/0x2B → ALUOp 12/13.
- sll/srl/sra 0x00/0x02/0x03 → ALUOp 3/4/5; sllv/srlv/srav 0x04/0x06/0x07 → ALUOp 6/7/8.
- mult/multu/div/divu 0x18–0x1B → MDOp 1–4, start=1, reg_we=0.
- mthi 0x11 and mtlo 0x13 → MDOp 5/6, reg_we=0. mfhi 0x10 and mflo 0x12 → MDOp 7/8.
- jr 0x08 → reg_we=0. jalr 0x09 → reg_we=1, reg_dst=0.

I-type, all with imm_sel=1, reg_dst=1 and reg_we=1 unless noted:
- addi 0x08 and addiu 0x09 → ALUOp 0, ext_op 1. slti 0x0A and sltiu 0x0B → ALUOp 12/13, ext_op 1.
- andi/ori/xori 0x0C/0x0D/0x0E → ALUOp 9/2/10, ext_op 0.
- lui 0x0F → ALUOp 0, ext_op 2.
- Loads lb/lh/lw/lbu/lhu (0x20/0x21/0x23/0x24/0x25) → ALUOp 0, ext_op 1.
- Stores sb/sh/sw (0x28/0x29/0x2B) → ALUOp 0, ext_op 1, reg_we=0.
- Branches beq/bne/blez/bgtz (0x04–0x07) and bltz/bgez (op 0x01, rt 0/1) → ALUOp 1, reg_we=0.
- j 0x02 → reg_we=0. jal 0x03 → reg_dst=2, reg_we=1.

Overflow and reserved flags:
- add_instr=1 only for add and addi. sub_instr=1 only for sub.
- An all-zero word decodes as sll with no reserved flag.
- Any other op/funct combination sets ri=1 and forces every other output to 0. ALUOp is 15 in that case.

Outputs not named for an instruction are 0.

## Timing
- Default build: purely combinational, zero latency. clk and reset are ignored.
- Registered build: every output is captured on the posedge of clk, giving 1-cycle latency.
- Registered-build reset: reset is checked at the posedge and has priority over capture. Every registered output, including ALUOp and MDOp, goes to 0.
- Registered-build reset mid-stream: the instruction presented during the reset cycle is discarded, and the first valid output appears 1 cycle after reset deasserts.

## Configuration
- `DECODE_REG_OUT_EN` defined: all outputs are registered as described in Timing.
- `DECODE_REG_OUT_EN` undefined: outputs are combinational and no flops are inferred.

## Test plan
- `0x00221820` (add $3,$1,$2) → ALUOp 0, add_instr 1, reg_we 1, reg_dst 0, imm_sel 0, ri 0.
- `0x00221822` (sub) → ALUOp 1, sub_instr 1, add_instr 0. `0x00221823` (subu) → sub_instr 0.
- `0x00220018` (mult $1,$2) → MDOp 1, start 1, reg_we 0. `0x00001810` (mfhi $3) → MDOp 7, start 0, reg_we 1.
- `0x34011234` (ori $1,$0,0x1234) → ALUOp 2, imm_sel 1, ext_op 0, reg_dst 1, reg_we 1.
- `0xFC000000` → ri 1, ALUOp 15, all other outputs 0. `0x00000000` → ALUOp 3, ri 0.
- With `DECODE_REG_OUT_EN`: assert reset with the add word applied → outputs 0. Deassert reset → ALUOp 0 and add_instr 1 appear at the next posedge.
